irq_controller: RTL and testbench

//   Machine-external interrupt controller on the requester side of the core's meip/irq_ack interface.

---
 rtl/irq_controller_pkg.sv | 19 +
 rtl/irq_controller_priority_enc.sv | 24 ++
 rtl/irq_controller.sv | 178 +++++++++++++++++
 tb/tb_irq_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants for the machine-external interrupt controller:
// register word offsets (wb_adr_i[4:2]) and the request FSM encoding.
package irq_controller_pkg;

  localparam logic [2:0] REG_PENDING  = 3'd0;
  localparam logic [2:0] REG_ENABLE   = 3'd1;
  localparam logic [2:0] REG_EDGE     = 3'd2;
  localparam logic [2:0] REG_CLAIM    = 3'd3;
  localparam logic [2:0] REG_COMPLETE = 3'd4;

  localparam int ID_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_INSERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_controller_priority_enc.sv
// Fixed-priority encoder: lowest set candidate index wins, reported as id = index+1,
// with id 0 meaning no candidate.
module irq_priority_enc
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] cand,
  output logic [ID_W-1:0]    winner
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    winner = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = 5'(i + 1);
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Machine-external interrupt controller: synchronizes and latches NUM_SRC sources,
// requests meip_o from the core and tracks claim/complete through a Wishbone slave.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               meip_o,
  input  logic               irq_ack_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o
);

  logic [NUM_SRC-1:0] sync1_r, sync2_r, src_prev_r, src_s, rise_s;
  logic [NUM_SRC-1:0] pending_r, enable_r, edge_r;
  logic [NUM_SRC-1:0] cand_s, claim_clr_s, w1c_s, edge_nxt_s, pending_nxt_s;
  logic [ID_W-1:0]    winner_s, claim_id_r;
  irq_state_e         state_r;
  logic               meip_r, ack_r;
  logic [31:0]        dat_r, rd_data_s;
  logic               access_s, wr_s, ack_take_s, complete_s;
  logic               unused_s;

  assign unused_s = ^{wb_adr_i[1:0], wb_dat_i};

  // Input synchronizers and previous-value register for edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_r    <= {NUM_SRC{1'b0}};
      sync2_r    <= {NUM_SRC{1'b0}};
      src_prev_r <= {NUM_SRC{1'b0}};
    end else begin
      sync1_r    <= irq_src_i;
      sync2_r    <= sync1_r;
      src_prev_r <= src_s;
    end
  end

  assign src_s  = SYNC_EN ? sync2_r : irq_src_i;
  assign rise_s = src_s & ~src_prev_r;
  assign cand_s = pending_r & enable_r;

  irq_priority_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .cand   (cand_s),
    .winner (winner_s)
  );

  // A bus access is taken on the edge that raises ack, so writes land there.
  assign access_s   = wb_cyc_i & wb_stb_i & ~ack_r;
  assign wr_s       = access_s & wb_we_i;
  assign w1c_s      = (wr_s && wb_adr_i[4:2] == REG_PENDING) ? wb_dat_i[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
  assign edge_nxt_s = (wr_s && wb_adr_i[4:2] == REG_EDGE) ? wb_dat_i[NUM_SRC-1:0] : edge_r;
  assign ack_take_s = (state_r == ST_REQ) && irq_ack_i && (winner_s != 5'd0);
  assign complete_s = wr_s && (wb_adr_i[4:2] == REG_COMPLETE) && (wb_dat_i[4:0] == claim_id_r);

  // Next pending state: mode switch clears, edge set beats clears, level tracks the line.
  always_comb begin
    claim_clr_s   = {NUM_SRC{1'b0}};
    pending_nxt_s = pending_r;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_take_s && winner_s == 5'(i + 1)) begin
        claim_clr_s[i] = 1'b1;
      end else begin
        claim_clr_s[i] = 1'b0;
      end
      if (edge_nxt_s[i] != edge_r[i]) begin
        pending_nxt_s[i] = 1'b0;
      end else if (edge_r[i]) begin
        if (rise_s[i]) begin
          pending_nxt_s[i] = 1'b1;
        end else if (w1c_s[i] || claim_clr_s[i]) begin
          pending_nxt_s[i] = 1'b0;
        end else begin
          pending_nxt_s[i] = pending_r[i];
        end
      end else begin
        pending_nxt_s[i] = src_s[i];
      end
    end
  end

  // Register read mux.
  always_comb begin
    rd_data_s = 32'd0;
    case (wb_adr_i[4:2])
      REG_PENDING: rd_data_s = 32'(pending_r);
      REG_ENABLE:  rd_data_s = 32'(enable_r);
      REG_EDGE:    rd_data_s = 32'(edge_r);
      REG_CLAIM:   rd_data_s = {27'd0, claim_id_r};
      default:     rd_data_s = 32'd0;
    endcase
  end

  // Software-visible registers and the Wishbone response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_r <= {NUM_SRC{1'b0}};
      enable_r  <= {NUM_SRC{1'b0}};
      edge_r    <= {NUM_SRC{1'b0}};
      ack_r     <= 1'b0;
      dat_r     <= 32'd0;
    end else begin
      pending_r <= pending_nxt_s;
      edge_r    <= edge_nxt_s;
      ack_r     <= wb_cyc_i & wb_stb_i & ~ack_r;
      if (wr_s && wb_adr_i[4:2] == REG_ENABLE) begin
        enable_r <= wb_dat_i[NUM_SRC-1:0];
      end else begin
        enable_r <= enable_r;
      end
      if (access_s && !wb_we_i) begin
        dat_r <= rd_data_s;
      end else begin
        dat_r <= 32'd0;
      end
    end
  end

  // Request / claim / complete sequencing towards the core.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      meip_r     <= 1'b0;
      claim_id_r <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|cand_s) begin
            state_r <= ST_REQ;
            meip_r  <= 1'b1;
          end else begin
            meip_r  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (irq_ack_i) begin
            claim_id_r <= winner_s;
            meip_r     <= 1'b0;
            state_r    <= (winner_s != 5'd0) ? ST_INSERVICE : ST_IDLE;
          end else if (!(|cand_s)) begin
            meip_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            meip_r  <= 1'b1;
          end
        end
        ST_INSERVICE: begin
          meip_r <= 1'b0;
          if (complete_s) begin
            claim_id_r <= 5'd0;
            state_r    <= ST_IDLE;
          end else begin
            state_r    <= ST_INSERVICE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          meip_r     <= 1'b0;
          claim_id_r <= 5'd0;
        end
      endcase
    end
  end

  assign meip_o   = meip_r;
  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NUM_SRC=8, SYNC_EN=1) with hand-computed expectations.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  irq_src_i = 8'h00;
  logic        meip_o;
  logic        irq_ack_i = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = 5'h00;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] rd;
  logic        rack;

  irq_controller #(.NUM_SRC(8), .SYNC_EN(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i), .irq_src_i(irq_src_i), .meip_o(meip_o),
    .irq_ack_i(irq_ack_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [4:0] adr, output logic [31:0] dat, output logic ack);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    tick();
    dat = wb_dat_o;
    ack = wb_ack_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
  endtask

  task automatic pulse_ack();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL rst_meip: got %0h want 0", meip_o); end
    vec_cnt++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin err_cnt++; $display("FAIL rst_bus: got ack %0h dat %0h want 0/0", wb_ack_o, wb_dat_o); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_pending: got %0h want 0", rd); end
    wb_read(5'h04, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_enable: got %0h want 0", rd); end
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL rst_claim: got %0h want 0", rd); end
  endtask

  task automatic test_single_edge();
    wb_write(5'h08, 32'hFF);
    wb_write(5'h04, 32'h04);
    irq_src_i = 8'h04;
    tick();
    irq_src_i = 8'h00;
    tick(); tick();
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t1_meip_early: got %0h want 0", meip_o); end
    tick();
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t1_meip_lat3: got %0h want 1", meip_o); end
    pulse_ack();
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t1_meip_ack: got %0h want 0", meip_o); end
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h3) begin err_cnt++; $display("FAIL t1_claim: got %0h want 3", rd); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t1_pending: got %0h want 0", rd); end
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t1_meip_stay: got %0h want 0", meip_o); end
    wb_write(5'h10, 32'h3);
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t1_claim_done: got %0h want 0", rd); end
  endtask

  task automatic test_priority();
    wb_write(5'h04, 32'hFF);
    irq_src_i = 8'h22;
    tick();
    irq_src_i = 8'h00;
    tick(); tick(); tick();
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t2_meip: got %0h want 1", meip_o); end
    pulse_ack();
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h2) begin err_cnt++; $display("FAIL t2_claim_first: got %0h want 2", rd); end
    wb_write(5'h10, 32'h2);
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t2_meip_again: got %0h want 1", meip_o); end
    pulse_ack();
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h6) begin err_cnt++; $display("FAIL t2_claim_second: got %0h want 6", rd); end
    wb_write(5'h10, 32'h6);
    tick();
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t2_meip_idle: got %0h want 0", meip_o); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t2_pending: got %0h want 0", rd); end
  endtask

  task automatic test_level();
    wb_write(5'h08, 32'hFE);
    wb_write(5'h04, 32'h01);
    irq_src_i = 8'h01;
    tick(); tick(); tick(); tick();
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t3_meip: got %0h want 1", meip_o); end
    pulse_ack();
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t3_meip_ack: got %0h want 0", meip_o); end
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t3_claim: got %0h want 1", rd); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t3_pending_level: got %0h want 1", rd); end
    wb_write(5'h10, 32'h1);
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t3_meip_reenter: got %0h want 1", meip_o); end
    wb_write(5'h00, 32'h1);
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t3_w1c_level: got %0h want 1", rd); end
    irq_src_i = 8'h00;
    tick(); tick(); tick(); tick();
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t3_meip_release: got %0h want 0", meip_o); end
  endtask

  task automatic test_mask_and_inservice();
    wb_write(5'h08, 32'hFF);
    irq_src_i = 8'h01;
    tick();
    irq_src_i = 8'h00;
    tick(); tick(); tick();
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t4_meip: got %0h want 1", meip_o); end
    wb_write(5'h04, 32'h00);
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t4_meip_masked: got %0h want 0", meip_o); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t4_pending_kept: got %0h want 1", rd); end
    wb_write(5'h04, 32'h01);
    vec_cnt++; if (meip_o !== 1'b1) begin err_cnt++; $display("FAIL t4_meip_unmask: got %0h want 1", meip_o); end
    pulse_ack();
    wb_write(5'h10, 32'h5);
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t4_wrong_complete: got %0h want 1", rd); end
    pulse_ack();
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t4_extra_ack: got %0h want 1", rd); end
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t4_meip_inservice: got %0h want 0", meip_o); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t4_pending_claimed: got %0h want 0", rd); end
    wb_write(5'h10, 32'h1);
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t4_claim_done: got %0h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    logic [3:0] got_ack;
    exp_ack = 4'b1010;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'h04;
    got_ack[3] = wb_ack_o;
    for (int k = 2; k >= 0; k--) begin
      tick();
      got_ack[k] = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    vec_cnt++; if (got_ack !== ~exp_ack) begin err_cnt++; $display("FAIL t5_ack_pattern: got %b want 0101", got_ack); end
    wb_read(5'h14, rd, rack);
    vec_cnt++; if (rd !== 32'h0 || rack !== 1'b1) begin err_cnt++; $display("FAIL t5_unmapped_read: got dat %0h ack %0h want 0/1", rd, rack); end
    wb_write(5'h14, 32'hFFFF_FFFF);
    wb_read(5'h04, rd, rack);
    vec_cnt++; if (rd !== 32'h1) begin err_cnt++; $display("FAIL t5_unmapped_write_enable: got %0h want 1", rd); end
    wb_read(5'h08, rd, rack);
    vec_cnt++; if (rd !== 32'hFF) begin err_cnt++; $display("FAIL t5_unmapped_write_edge: got %0h want ff", rd); end
    wb_read(5'h10, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t5_complete_read: got %0h want 0", rd); end
  endtask

  task automatic test_reset_inservice();
    irq_src_i = 8'h03;
    tick();
    irq_src_i = 8'h00;
    tick(); tick(); tick();
    pulse_ack();
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h2) begin err_cnt++; $display("FAIL t6_pending_pre: got %0h want 2", rd); end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    vec_cnt++; if (meip_o !== 1'b0) begin err_cnt++; $display("FAIL t6_meip: got %0h want 0", meip_o); end
    wb_read(5'h0C, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t6_claim: got %0h want 0", rd); end
    wb_read(5'h04, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t6_enable: got %0h want 0", rd); end
    wb_read(5'h00, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t6_pending: got %0h want 0", rd); end
    wb_read(5'h08, rd, rack);
    vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL t6_edge: got %0h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_level();
    test_mask_and_inservice();
    test_back_to_back();
    test_reset_inservice();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
